// File: rtl/sort_pkg.sv
// Shared constants and vector type for the sorter and its output serializer.
package sort_pkg;

    localparam int unsigned DEFAULT_DEPTH = 8;
    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned IDX_W         = $clog2(DEFAULT_DEPTH);

    // Same shape as the sorter's seq_out port: element 0 first.
    typedef logic [DEFAULT_WIDTH-1:0] vec_t [DEFAULT_DEPTH];

endpackage

// File: rtl/sort_stream_out_if.sv
// Ready/valid element stream leaving the serializer, with position and last flag.
interface sort_stream_out_if
    import sort_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    localparam int unsigned IW = $clog2(DEPTH);

    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [IW-1:0]    m_index;
    logic             m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_index,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_index,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/sort_slot_buf.sv
// Two-slot vector store: write/read pointers and a 0..2 occupancy count.
module sort_slot_buf
    import sort_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_vec [DEPTH],
    input  logic             drain,
    output logic             not_empty,
    output logic             full,
    output logic [WIDTH-1:0] rd_vec [DEPTH]
);

    logic [WIDTH-1:0] slot [2][DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             capture;

    // A drain in the same cycle frees the read slot, so a full buffer can still accept.
    assign capture   = wr_req && (!full || drain);
    assign not_empty = (count != 2'd0);
    assign full      = (count == 2'd2);

    // Slot data is not reset; it is only observable through a nonzero count.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot[wr_ptr][i] <= wr_vec[i];
            end
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (capture) wr_ptr <= ~wr_ptr;
            if (drain)   rd_ptr <= ~rd_ptr;
            case ({capture, drain})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Present the vector currently being streamed.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd_vec[i] = slot[rd_ptr][i];
        end
    end

endmodule

// File: rtl/sort_stream_out.sv
// Serializes buffered sorted vectors onto a ready/valid stream; counts dropped vectors.
module sort_stream_out
    import sort_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vec_valid,
    input  logic [WIDTH-1:0]         vec_in [DEPTH],
    sort_stream_out_if.master        m,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    logic [IW-1:0]    idx;
    logic             not_empty;
    logic             full;
    logic             hs;
    logic             drain;
    logic             drop;
    logic [WIDTH-1:0] rd_vec [DEPTH];

    sort_slot_buf #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_req    (vec_valid),
        .wr_vec    (vec_in),
        .drain     (drain),
        .not_empty (not_empty),
        .full      (full),
        .rd_vec    (rd_vec)
    );

    assign hs    = not_empty && m.m_ready;
    assign drain = hs && (idx == LAST_IDX);
    assign drop  = vec_valid && full && !drain;

    // Element position within the vector being streamed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (drain) begin
            idx <= '0;
        end else if (hs) begin
            idx <= idx + 1'b1;
        end
    end

    // Drop reporting: one-cycle pulse and saturating counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            overflow <= drop;
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Stream outputs, all derived from registered state.
    always_comb begin
        m.m_valid = not_empty;
        m.m_data  = not_empty ? rd_vec[idx] : '0;
        m.m_index = idx;
        m.m_last  = not_empty && (idx == LAST_IDX);
    end

endmodule

// File: tb/tb_sort_stream_out.sv
// Self-checking bench for sort_stream_out: directed table, corner sequences, random run.
module tb_sort_stream_out;
    import sort_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             vec_valid;
    logic [WIDTH-1:0] vec_in [DEPTH];
    logic             overflow;
    logic [7:0]       drop_cnt;

    always #5 clk = ~clk;

    sort_stream_out_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    sort_stream_out #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vec_valid (vec_valid),
        .vec_in    (vec_in),
        .m         (bus),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: flat FIFO of elements; vectors held = ceil(elements / DEPTH).
    logic [31:0] mq [$];
    logic        exp_ovf = 1'b0;
    int          exp_drops = 0;

    function automatic int m_vecs();
        return (mq.size() + DEPTH - 1) / DEPTH;
    endfunction

    function automatic int m_pos();
        return (DEPTH - (mq.size() % DEPTH)) % DEPTH;
    endfunction

    task automatic model_clear();
        mq.delete();
        exp_ovf   = 1'b0;
        exp_drops = 0;
    endtask

    task automatic check_model();
        logic ev;
        ev = (mq.size() != 0);
        chk("m_valid", bus.m_valid, ev);
        chk("m_data", bus.m_data, ev ? mq[0] : 32'd0);
        chk("m_index", bus.m_index, m_pos());
        chk("m_last", bus.m_last, ev && m_pos() == DEPTH - 1);
        chk("overflow", overflow, exp_ovf);
        chk("drop_cnt", drop_cnt, exp_drops);
    endtask

    // Check current outputs, advance one clock, then update the model.
    task automatic tick();
        logic        v;
        logic        r;
        logic        ev;
        logic        drop;
        logic [31:0] d [DEPTH];
        check_model();
        v  = vec_valid;
        r  = bus.m_ready;
        d  = vec_in;
        ev = (mq.size() != 0);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_clear();
            return;
        end
        if (ev && r) void'(mq.pop_front());
        drop = 1'b0;
        if (v) begin
            if (m_vecs() < 2) begin
                for (int i = 0; i < DEPTH; i++) mq.push_back(d[i]);
            end else begin
                drop = 1'b1;
            end
        end
        exp_ovf = drop;
        if (drop && exp_drops < 255) exp_drops++;
    endtask

    task automatic send(input logic [31:0] base);
        for (int i = 0; i < DEPTH; i++) vec_in[i] = base + 32'(i);
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rdy;
        logic        vld;
        logic [31:0] data;
        logic [31:0] idx;
        logic        last;
    } rec_t;

    rec_t        t1 [9];
    logic [31:0] got [$];
    logic [31:0] prev_data;
    logic        prev_stall;

    initial begin
        // Single free-flowing vector {1..8}: cycles 1..8 carry data, cycle 9 is idle.
        for (int i = 0; i < 8; i++) t1[i] = '{1'b1, 1'b1, 32'(i + 1), 32'(i), i == 7};
        t1[8] = '{1'b1, 1'b0, 32'd0, 32'd0, 1'b0};

        vec_valid   = 1'b0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) vec_in[i] = '0;
        #1;
        chk("rst m_valid", bus.m_valid, 0);
        chk("rst m_index", bus.m_index, 0);
        chk("rst m_data", bus.m_data, 0);
        chk("rst drop_cnt", drop_cnt, 0);
        do_reset();

        // Scenario 1: table-driven
        bus.m_ready = 1'b1;
        send(32'd1);
        for (int c = 0; c < 9; c++) begin
            bus.m_ready = t1[c].rdy;
            chk($sformatf("t1[%0d] valid", c), bus.m_valid, t1[c].vld);
            chk($sformatf("t1[%0d] data", c), bus.m_data, t1[c].data);
            chk($sformatf("t1[%0d] index", c), bus.m_index, t1[c].idx);
            chk($sformatf("t1[%0d] last", c), bus.m_last, t1[c].last);
            tick();
        end

        // Scenario 2: backpressure toggling 1,0,1,0
        got.delete();
        prev_stall = 1'b0;
        prev_data  = '0;
        send(32'd41);
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            bus.m_ready = (c % 2 == 0);
            if (prev_stall) chk("bp hold", bus.m_data, prev_data);
            if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            tick();
        end
        chk("bp count", got.size(), 8);
        for (int i = 0; i < got.size(); i++) chk("bp elem", got[i], 32'd41 + 32'(i));

        // Scenario 3: overflow on third back-to-back vector
        bus.m_ready = 1'b0;
        tick();
        send(32'd1);
        send(32'd11);
        send(32'd21);
        chk("ovf pulse", overflow, 1);
        chk("ovf drop_cnt", drop_cnt, 1);
        got.delete();
        bus.m_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
            tick();
        end
        chk("ovf count", got.size(), 16);
        for (int i = 0; i < got.size() && i < 16; i++)
            chk("ovf elem", got[i], (i < 8) ? 32'(i + 1) : 32'(i + 3));

        // Scenario 4: capture coinciding with drain while full
        bus.m_ready = 1'b0;
        send(32'd51);
        send(32'd61);
        bus.m_ready = 1'b1;
        for (int c = 0; c < 20 && !(bus.m_valid && bus.m_index == 3'd7); c++) tick();
        chk("sim at last", bus.m_last, 1);
        send(32'd71);
        chk("sim no ovf", overflow, 0);
        chk("sim next vec", bus.m_data, 32'd61);
        for (int c = 0; c < 20; c++) tick();

        // Scenario 5: reset mid-drain
        send(32'd81);
        for (int c = 0; c < 20 && !(bus.m_valid && bus.m_index == 3'd3); c++) tick();
        chk("rstmid idx", bus.m_index, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid valid", bus.m_valid, 0);
        chk("rstmid index", bus.m_index, 0);
        chk("rstmid data", bus.m_data, 0);
        model_clear();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("post rst idle", bus.m_valid, 0);
            tick();
        end

        // Scenario 6: drop counter saturation
        bus.m_ready = 1'b0;
        send(32'd91);
        send(32'd101);
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < DEPTH; i++) vec_in[i] = $urandom;
            vec_valid = 1'b1;
            tick();
        end
        vec_valid = 1'b0;
        chk("sat drop_cnt", drop_cnt, 255);
        chk("sat ovf", overflow, 1);
        tick();
        chk("sat ovf clear", overflow, 0);
        bus.m_ready = 1'b1;
        for (int c = 0; c < 20; c++) tick();

        // Randomized run against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            vec_valid = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < DEPTH; i++) vec_in[i] = $urandom;
            bus.m_ready = (c < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            tick();
        end
        vec_valid   = 1'b0;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        chk("final empty", bus.m_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
